// File: rtl/pwm_dead_time_modulator.sv
// Complementary PWM pair with dead-time insertion and period-aligned
// duty/enable sampling; announces each period with a one-cycle strobe.
module pwm_dead_time_modulator #(
    parameter int PRESCALE  = 1,
    parameter int DEAD_TIME = 2
) (
    input  logic       sysclk,
    input  logic       Reset_n,
    input  logic       Enable,
    input  logic [5:0] Duty_Input,
    output logic       PWM_High,
    output logic       PWM_Low,
    output logic       Period_Start,
    output logic       Active
);

    typedef enum logic [1:0] {IDLE, HIGH, LOW, DEAD} state_t;

    localparam logic [9:0] TICK_MAX = 10'(PRESCALE - 1);
    localparam logic [7:0] DT_START = 8'(DEAD_TIME);
    localparam logic [7:0] DT_SWAP  = (DEAD_TIME > 0) ? 8'(DEAD_TIME - 1) : 8'd0;
    localparam bit         NO_DEAD  = (DEAD_TIME == 0);

    state_t     state, state_nxt;
    logic [9:0] tick_cnt;
    logic [5:0] phase;
    logic [5:0] duty_reg;
    logic [7:0] dead_cnt, dead_nxt;
    logic       tick, running, start, period_end, boundary, raw;

    assign tick       = (tick_cnt == TICK_MAX);
    assign running    = (state != IDLE);
    assign start      = !running && Enable;
    assign period_end = running && tick && (phase == 6'd63);
    assign boundary   = start || period_end;
    assign raw        = (phase < duty_reg);

    // Counters are frozen at zero while idle so a restart is always aligned.
    always_ff @(posedge sysclk or negedge Reset_n) begin
        if (!Reset_n) begin
            tick_cnt     <= '0;
            phase        <= '0;
            duty_reg     <= '0;
            Period_Start <= 1'b0;
            Active       <= 1'b0;
        end else begin
            Period_Start <= boundary && Enable;
            if (boundary) begin
                tick_cnt <= '0;
                phase    <= '0;
                Active   <= Enable;
                if (Enable)
                    duty_reg <= Duty_Input;
            end else if (running) begin
                if (tick) begin
                    tick_cnt <= '0;
                    phase    <= phase + 6'd1;
                end else begin
                    tick_cnt <= tick_cnt + 10'd1;
                end
            end
        end
    end

    // Start-up dead window lasts DEAD_TIME+1 cycles; swaps last DEAD_TIME.
    always_comb begin
        state_nxt = state;
        dead_nxt  = dead_cnt;
        if (period_end && !Enable) begin
            state_nxt = IDLE;
            dead_nxt  = '0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (Enable) begin
                        state_nxt = DEAD;
                        dead_nxt  = DT_START;
                    end
                end
                HIGH: begin
                    if (!raw) begin
                        state_nxt = NO_DEAD ? LOW : DEAD;
                        dead_nxt  = DT_SWAP;
                    end
                end
                LOW: begin
                    if (raw) begin
                        state_nxt = NO_DEAD ? HIGH : DEAD;
                        dead_nxt  = DT_SWAP;
                    end
                end
                DEAD: begin
                    if (dead_cnt == 8'd0)
                        state_nxt = raw ? HIGH : LOW;
                    else
                        dead_nxt = dead_cnt - 8'd1;
                end
                default: state_nxt = IDLE;
            endcase
        end
    end

    always_ff @(posedge sysclk or negedge Reset_n) begin
        if (!Reset_n) begin
            state    <= IDLE;
            dead_cnt <= '0;
            PWM_High <= 1'b0;
            PWM_Low  <= 1'b0;
        end else begin
            state    <= state_nxt;
            dead_cnt <= dead_nxt;
            PWM_High <= (state_nxt == HIGH);
            PWM_Low  <= (state_nxt == LOW);
        end
    end

endmodule
